// File: rtl/cpu_pkg.sv
// Shared CPU constants: bus widths, opcode map and fetch FSM state encoding.
package cpu_pkg;

  localparam int CPU_ADDR_W = 4;
  localparam int CPU_DATA_W = 8;
  localparam int CPU_OPC_W  = 4;

  localparam logic [CPU_OPC_W-1:0] OPC_NOP = 4'h0;
  localparam logic [CPU_OPC_W-1:0] OPC_LDA = 4'h1;
  localparam logic [CPU_OPC_W-1:0] OPC_ADD = 4'h2;
  localparam logic [CPU_OPC_W-1:0] OPC_SUB = 4'h3;
  localparam logic [CPU_OPC_W-1:0] OPC_STA = 4'h4;
  localparam logic [CPU_OPC_W-1:0] OPC_JMP = 4'h6;
  localparam logic [CPU_OPC_W-1:0] OPC_OUT = 4'hE;
  localparam logic [CPU_OPC_W-1:0] OPC_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_VALID   = 3'd3,
    S_HALTED  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/prog_counter.sv
// Program counter: synchronous reset, load beats increment, wraps modulo 2^ADDR_W.
module prog_counter #(
  parameter int                ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              res,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (res)       pc <= RESET_PC;
    else if (load) pc <= load_addr;
    else if (inc)  pc <= pc + ADDR_W'(1);
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, pulses a 1-cycle-latency memory read,
// latches the word into IR and offers it over valid/ready.
// Define FETCH_HLT_DETECT_EN to make the HLT opcode stop fetch (sticky until res).
module instr_fetch import cpu_pkg::*; #(
  parameter int                ADDR_W     = CPU_ADDR_W,
  parameter int                DATA_W     = CPU_DATA_W,
  parameter int                OPC_W      = CPU_OPC_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [OPC_W-1:0]  HLT_OPCODE = OPC_HLT
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    run,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic                    ram_en,
  input  logic [DATA_W-1:0]       ram_data,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [OPC_W-1:0]        opcode,
  output logic [DATA_W-OPC_W-1:0] operand,
  output logic [ADDR_W-1:0]       pc,
  input  logic                    jump_en,
  input  logic [ADDR_W-1:0]       jump_addr,
  output logic                    halted
);

`ifdef FETCH_HLT_DETECT_EN
  localparam bit HLT_EN = 1'b1;
`else
  localparam bit HLT_EN = 1'b0;
`endif

  fetch_state_e      state, state_nxt;
  logic [DATA_W-1:0] ir;
  logic              hs, hlt_hit, pc_load, pc_inc;

  assign hs      = instr_valid & instr_ready;
  assign hlt_hit = HLT_EN && (ram_data[DATA_W-1 -: OPC_W] == HLT_OPCODE);
  assign pc_load = (state == S_VALID) && hs && jump_en;
  assign pc_inc  = (state == S_CAPTURE);

  prog_counter #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk       (clk),
    .res       (res),
    .load      (pc_load),
    .inc       (pc_inc),
    .load_addr (jump_addr),
    .pc        (pc)
  );

  always_ff @(posedge clk) begin
    if (res) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (run) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = run ? S_CAPTURE : S_IDLE;
      S_CAPTURE: state_nxt = hlt_hit ? S_HALTED : S_VALID;
      S_VALID:   if (hs) state_nxt = run ? S_ISSUE : S_IDLE;
      S_HALTED:  state_nxt = S_HALTED;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // A read is only launched if run is still high in ISSUE; otherwise it is abandoned.
  always_comb begin
    ram_en      = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      S_ISSUE:  ram_en      = run;
      S_VALID:  instr_valid = 1'b1;
      S_HALTED: halted      = HLT_EN;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res)                     ir <= '0;
    else if (state == S_CAPTURE) ir <= ram_data;
  end

  assign ram_addr = pc;
  assign opcode   = ir[DATA_W-1 -: OPC_W];
  assign operand  = ir[DATA_W-OPC_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: issued reads push the model memory word,
// handshakes pop and compare the presented opcode/operand.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       res, run, ram_en, instr_valid, instr_ready, jump_en, halted;
  logic [3:0] ram_addr, opcode, pc, jump_addr;
  logic [3:0] operand;
  logic [7:0] ram_data = 8'h00;
  logic [7:0] mem [16];

  int         n_cmp = 0, n_err = 0;
  int         en_cnt = 0, pops = 0;
  logic [7:0] exp_q [$];
  logic [3:0] pc_m = 4'h0;

  instr_fetch dut (
    .clk         (clk),
    .res         (res),
    .run         (run),
    .ram_addr    (ram_addr),
    .ram_en      (ram_en),
    .ram_data    (ram_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .operand     (operand),
    .pc          (pc),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Registered-read memory, 1-cycle latency, output not reset.
  always @(posedge clk) if (ram_en) ram_data <= mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: tracks its own PC model from issued reads and jumps.
  always @(negedge clk) begin
    if (res) begin
      exp_q.delete();
      pc_m = 4'h0;
    end else begin
      if (ram_en) begin
        en_cnt++;
        chk("ram_addr", ram_addr, pc_m);
        exp_q.push_back(mem[pc_m]);
        pc_m = pc_m + 4'h1;
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) chk("sb_empty", exp_q.size(), 1);
        else begin
          pops++;
          chk("instr", {opcode, operand}, exp_q.pop_front());
          if (jump_en) pc_m = jump_addr;
        end
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic drv;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    drv();
    res = 1'b1; run = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = 4'h0;
    drv();
    res = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30 && !instr_valid; i++) tick();
    chk(tag, instr_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, p0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i);
    mem[0] = 8'h4B; mem[1] = 8'h1F; mem[2] = 8'h2E; mem[3] = 8'hF0;
    mem[14] = 8'h2A; mem[15] = 8'h2F;

    res = 1'b1; run = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = 4'h0;
    repeat (2) @(posedge clk);
    #2 res = 1'b0;
    tick();
    chk("rst_pc", pc, 4'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_en", ram_en, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_ir", {opcode, operand}, 8'h00);

    // run low: nothing happens, then first ISSUE one cycle after run rises
    e0 = en_cnt;
    repeat (10) tick();
    chk("idle_en", en_cnt, e0);
    chk("idle_pc", pc, 4'h0);
    chk("idle_valid", instr_valid, 1'b0);
    drv(); run = 1'b1;
    tick();
    chk("idle_pre_en", ram_en, 1'b0);
    tick();
    chk("start_en", ram_en, 1'b1);
    chk("start_addr", ram_addr, 4'h0);

    // program run to the HLT word
    do_reset();
    p0 = pops;
    run = 1'b1; instr_ready = 1'b1;
`ifdef FETCH_HLT_DETECT_EN
    for (int i = 0; i < 60 && !halted; i++) tick();
    chk("halt_seen", halted, 1'b1);
    chk("halt_pops", pops - p0, 3);
    chk("halt_pc", pc, 4'h4);
    e0 = en_cnt;
    repeat (6) tick();
    chk("halt_no_en", en_cnt, e0);
    chk("halt_sticky", halted, 1'b1);
    chk("halt_valid", instr_valid, 1'b0);
    chk("halt_pc_frozen", pc, 4'h4);
`else
    for (int i = 0; i < 60 && (pops - p0) < 4; i++) tick();
    chk("nohlt_pops", pops - p0, 4);
    chk("nohlt_halted", halted, 1'b0);
`endif

    // downstream stall in VALID
    do_reset();
    run = 1'b1;
    wait_valid("stall_to_valid");
    e0 = en_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_instr", {opcode, operand}, 8'h4B);
      chk("stall_pc", pc, 4'h1);
    end
    chk("stall_no_en", en_cnt, e0);
    drv(); instr_ready = 1'b1;
    tick();
    drv(); instr_ready = 1'b0;
    tick();
    chk("hs_issue_en", ram_en, 1'b1);
    tick();
    chk("lat_cap_valid", instr_valid, 1'b0);
    tick();
    chk("lat_valid", instr_valid, 1'b1);
    chk("lat_instr", {opcode, operand}, 8'h1F);

    // jump on first handshake, then wrap 15 -> 0
    do_reset();
    run = 1'b1;
    wait_valid("jmp_to_valid");
    drv(); instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 4'hE;
    tick();
    drv(); instr_ready = 1'b0; jump_en = 1'b0;
    wait_valid("jmp_valid");
    chk("jmp_instr", {opcode, operand}, 8'h2A);
    chk("jmp_pc", pc, 4'hF);
    drv(); instr_ready = 1'b1;
    tick();
    drv(); instr_ready = 1'b0;
    wait_valid("wrap_valid");
    chk("wrap_instr", {opcode, operand}, 8'h2F);
    chk("wrap_pc", pc, 4'h0);
    drv(); instr_ready = 1'b1;
    tick();
    drv(); instr_ready = 1'b0;
    tick();
    chk("wrap_en", ram_en, 1'b1);
    chk("wrap_addr", ram_addr, 4'h0);

    // reset landing on CAPTURE
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 10 && !ram_en; i++) tick();
    chk("rc_issue", ram_en, 1'b1);
    drv(); res = 1'b1;
    drv(); res = 1'b0; run = 1'b0;
    tick();
    chk("rc_valid", instr_valid, 1'b0);
    chk("rc_pc", pc, 4'h0);
    chk("rc_ir", {opcode, operand}, 8'h00);
    chk("rc_en", ram_en, 1'b0);
    repeat (3) tick();
    chk("rc_still_idle", instr_valid, 1'b0);
    run = 1'b1; instr_ready = 1'b0;
    wait_valid("rc_refetch");
    chk("rc_instr", {opcode, operand}, 8'h4B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
